// File: rtl/cva5_fifo_occ.sv
// Parametrised FIFO with occupancy count, programmable almost-full, synchronous flush
// and sticky overflow/underflow error flags. Depth may be any integer in 1..64.
module cva5_fifo_occ #(
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int AF_THRESHOLD = FIFO_DEPTH - 1,
  localparam int CW          = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid,
  output logic                  full,
  output logic                  almost_full,
  output logic [CW-1:0]         count,
  output logic                  overflow_err,
  output logic                  underflow_err,
  input  logic                  clear_err
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(AF_THRESHOLD);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  push_ok, pop_ok;

  // Binary wrap at FIFO_DEPTH-1; with a single entry this always yields 0.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign valid         = (count_q != '0);
  assign full          = (count_q == DEPTH_C);
  assign almost_full   = (count_q >= AF_C);
  assign count         = count_q;
  assign data_out      = mem_q[rd_ptr_q];
  assign overflow_err  = overflow_q;
  assign underflow_err = underflow_q;

  always_comb begin
    pop_ok  = pop & valid;
    // A pop in the same cycle frees the slot of a full FIFO.
    push_ok = push & (~full | pop_ok);

    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    // Legality is judged on the request itself, independent of flush; set beats clear.
    overflow_d  = (overflow_q & ~clear_err) | (push & ~push_ok);
    underflow_d = (underflow_q & ~clear_err) | (pop & ~pop_ok);

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = data_in;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop_ok) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_cva5_fifo_occ.sv
// Directed bench for cva5_fifo_occ: three configurations (depth 3, depth 4 / AF 2, depth 1)
// with a per-instance data scoreboard queue.
module tb_cva5_fifo_occ;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_v   = 3'b000;
  logic [2:0] flush_v = 3'b000;
  logic [2:0] push_v  = 3'b000;
  logic [2:0] pop_v   = 3'b000;
  logic [2:0] clr_v   = 3'b000;
  logic [7:0] din_v [3];
  logic [7:0] dout_v [3];
  logic [2:0] valid_v, full_v, af_v, ovf_v, unf_v;
  logic [1:0] cnt_a;
  logic [2:0] cnt_b;
  logic [0:0] cnt_c;
  logic [31:0] cnt_v [3];

  logic [7:0] sb [3][$];
  int depth [3] = '{3, 4, 1};
  int checks = 0;
  int errors = 0;

  assign cnt_v[0] = 32'(cnt_a);
  assign cnt_v[1] = 32'(cnt_b);
  assign cnt_v[2] = 32'(cnt_c);

  cva5_fifo_occ #(.DATA_WIDTH(8), .FIFO_DEPTH(3)) u_a (
    .clk(clk), .rst(rst_v[0]), .flush(flush_v[0]), .push(push_v[0]), .data_in(din_v[0]),
    .pop(pop_v[0]), .data_out(dout_v[0]), .valid(valid_v[0]), .full(full_v[0]),
    .almost_full(af_v[0]), .count(cnt_a), .overflow_err(ovf_v[0]),
    .underflow_err(unf_v[0]), .clear_err(clr_v[0]));

  cva5_fifo_occ #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .AF_THRESHOLD(2)) u_b (
    .clk(clk), .rst(rst_v[1]), .flush(flush_v[1]), .push(push_v[1]), .data_in(din_v[1]),
    .pop(pop_v[1]), .data_out(dout_v[1]), .valid(valid_v[1]), .full(full_v[1]),
    .almost_full(af_v[1]), .count(cnt_b), .overflow_err(ovf_v[1]),
    .underflow_err(unf_v[1]), .clear_err(clr_v[1]));

  cva5_fifo_occ #(.DATA_WIDTH(8), .FIFO_DEPTH(1), .AF_THRESHOLD(1)) u_c (
    .clk(clk), .rst(rst_v[2]), .flush(flush_v[2]), .push(push_v[2]), .data_in(din_v[2]),
    .pop(pop_v[2]), .data_out(dout_v[2]), .valid(valid_v[2]), .full(full_v[2]),
    .almost_full(af_v[2]), .count(cnt_c), .overflow_err(ovf_v[2]),
    .underflow_err(unf_v[2]), .clear_err(clr_v[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle of push/pop on unit u; the head is checked against the scoreboard
  // before the edge that consumes it, occupancy flags after the edge.
  task automatic step(input int u, input bit ps, input logic [7:0] d, input bit pp);
    int  n       = sb[u].size();
    bit  pop_ok  = pp && (n > 0);
    bit  push_ok = ps && ((n < depth[u]) || pop_ok);
    push_v[u] = ps;
    pop_v[u]  = pp;
    din_v[u]  = d;
    if (pop_ok) chk($sformatf("u%0d_head", u), 32'(dout_v[u]), 32'(sb[u].pop_front()));
    if (push_ok) sb[u].push_back(d);
    tick();
    push_v[u] = 1'b0;
    pop_v[u]  = 1'b0;
    n = sb[u].size();
    chk($sformatf("u%0d_count", u), cnt_v[u], 32'(n));
    chk($sformatf("u%0d_valid", u), 32'(valid_v[u]), 32'(n != 0));
    chk($sformatf("u%0d_full", u), 32'(full_v[u]), 32'(n == depth[u]));
  endtask

  initial begin
    for (int i = 0; i < 3; i++) din_v[i] = '0;

    rst_v = 3'b111;
    tick();
    tick();
    rst_v = 3'b000;
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("u%0d_rst_count", u), cnt_v[u], 32'd0);
      chk($sformatf("u%0d_rst_valid", u), 32'(valid_v[u]), 32'd0);
      chk($sformatf("u%0d_rst_full", u), 32'(full_v[u]), 32'd0);
      chk($sformatf("u%0d_rst_af", u), 32'(af_v[u]), 32'd0);
      chk($sformatf("u%0d_rst_ovf", u), 32'(ovf_v[u]), 32'd0);
      chk($sformatf("u%0d_rst_unf", u), 32'(unf_v[u]), 32'd0);
    end

    // Depth 3: fill, then drain in order.
    step(0, 1, 8'h11, 0);
    chk("a_count1", cnt_v[0], 32'd1);
    step(0, 1, 8'h22, 0);
    chk("a_count2", cnt_v[0], 32'd2);
    step(0, 1, 8'h33, 0);
    chk("a_count3", cnt_v[0], 32'd3);
    chk("a_full3", 32'(full_v[0]), 32'd1);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    chk("a_empty_valid", 32'(valid_v[0]), 32'd0);
    chk("a_empty_count", cnt_v[0], 32'd0);

    // Steady state at occupancy 1, crossing the non-power-of-two wrap several times.
    step(0, 1, 8'h00, 0);
    for (int i = 1; i < 10; i++) step(0, 1, 8'(i), 1);
    step(0, 0, 8'h00, 1);

    // Full: push with pop is legal, push alone is not.
    step(0, 1, 8'h11, 0);
    step(0, 1, 8'h22, 0);
    step(0, 1, 8'h33, 0);
    step(0, 1, 8'h44, 1);
    chk("a_pushpop_full_count", cnt_v[0], 32'd3);
    chk("a_pushpop_full_ovf", 32'(ovf_v[0]), 32'd0);
    step(0, 1, 8'h66, 0);
    chk("a_ovf_set", 32'(ovf_v[0]), 32'd1);
    chk("a_ovf_count", cnt_v[0], 32'd3);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);

    // Empty: pop with push -> underflow, the push still lands.
    step(0, 1, 8'h55, 1);
    chk("a_unf_set", 32'(unf_v[0]), 32'd1);
    chk("a_unf_count", cnt_v[0], 32'd1);
    chk("a_unf_dout", 32'(dout_v[0]), 32'h55);
    chk("a_ovf_sticky", 32'(ovf_v[0]), 32'd1);
    clr_v[0] = 1'b1;
    tick();
    clr_v[0] = 1'b0;
    chk("a_clr_ovf", 32'(ovf_v[0]), 32'd0);
    chk("a_clr_unf", 32'(unf_v[0]), 32'd0);
    step(0, 0, 8'h00, 1);

    // Depth 4, AF 2: almost_full boundary, then flush beats a simultaneous push.
    step(1, 1, 8'h01, 0);
    chk("b_af_at1", 32'(af_v[1]), 32'd0);
    step(1, 1, 8'h02, 0);
    chk("b_af_at2", 32'(af_v[1]), 32'd1);
    flush_v[1] = 1'b1;
    push_v[1]  = 1'b1;
    din_v[1]   = 8'h77;
    tick();
    flush_v[1] = 1'b0;
    push_v[1]  = 1'b0;
    sb[1].delete();
    chk("b_flush_count", cnt_v[1], 32'd0);
    chk("b_flush_valid", 32'(valid_v[1]), 32'd0);
    chk("b_flush_af", 32'(af_v[1]), 32'd0);
    step(1, 1, 8'h99, 0);
    chk("b_after_flush_dout", 32'(dout_v[1]), 32'h99);
    step(1, 0, 8'h00, 1);

    // Depth 1: alternate push/pop, then reset while full with both errors set.
    for (int i = 0; i < 4; i++) begin
      step(2, 1, 8'hA0 + 8'(i), 0);
      chk("c_full_hi", 32'(full_v[2]), 32'd1);
      chk("c_dout", 32'(dout_v[2]), 32'(8'hA0 + 8'(i)));
      step(2, 0, 8'h00, 1);
      chk("c_full_lo", 32'(full_v[2]), 32'd0);
    end
    step(2, 0, 8'h00, 1);
    chk("c_unf_set", 32'(unf_v[2]), 32'd1);
    step(2, 1, 8'hA4, 0);
    step(2, 1, 8'hA5, 0);
    chk("c_ovf_set", 32'(ovf_v[2]), 32'd1);
    chk("c_ovf_dout", 32'(dout_v[2]), 32'hA4);
    rst_v[2] = 1'b1;
    tick();
    rst_v[2] = 1'b0;
    sb[2].delete();
    chk("c_rst_count", cnt_v[2], 32'd0);
    chk("c_rst_valid", 32'(valid_v[2]), 32'd0);
    chk("c_rst_ovf", 32'(ovf_v[2]), 32'd0);
    chk("c_rst_unf", 32'(unf_v[2]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cva5_fifo_occ.md
Name: cva5_fifo_occ

Overview:
- Parametrised successor of the small core FIFOs, e.g. the divider result queue.
- Generalises data width and depth; depth need not be a power of two.
- Adds an occupancy count, a programmable almost-full flag, a synchronous flush, and sticky overflow/underflow error flags that replace assertion-only checking.
- Sits between issue/writeback-side producers and consumers inside functional units.

Parameters:
- DATA_WIDTH, 32, width of each stored word.
- FIFO_DEPTH, 4, number of entries; legal range 1..64, any integer.
- AF_THRESHOLD, FIFO_DEPTH-1, almost_full asserts when count >= AF_THRESHOLD; legal range 1..FIFO_DEPTH.
- CW (localparam), $clog2(FIFO_DEPTH+1), width of the count output.

Ports:
- clk  input  1  clock.
- rst  input  1  reset.
- flush  input  1  discard all contents.
- push  input  1  enqueue data_in this cycle.
- data_in  input  DATA_WIDTH  write data.
- pop  input  1  dequeue head entry this cycle.
- data_out  output  DATA_WIDTH  head entry; meaningful only when valid=1.
- valid  output  1  FIFO is non-empty.
- full  output  1  count == FIFO_DEPTH.
- almost_full  output  1  count >= AF_THRESHOLD.
- count  output  CW  current occupancy.
- overflow_err  output  1  sticky: an illegal push occurred.
- underflow_err  output  1  sticky: an illegal pop occurred.
- clear_err  input  1  clears both sticky error flags.

Behaviour:
- Single clock domain. Reset is synchronous and active-high on rst.
- Reset values: count=0, valid=0, full=0, almost_full=0, both read/write pointers=0, overflow_err=0, underflow_err=0. Storage contents are not reset; data_out is don't-care while valid=0.
- Storage: FIFO_DEPTH entries, written at the write pointer, read combinationally at the read pointer.
  - data_out reflects the head in the same cycle valid rises.
  - Zero-latency read; one-cycle write-to-visible latency (a push in cycle N is visible at cycle N+1).
- Pointers are binary and wrap from FIFO_DEPTH-1 to 0; no power-of-two rounding. For FIFO_DEPTH==1, both pointers are constant 0.
- Legal operations:
  - push is legal when full=0, or when full=1 and pop=1 in the same cycle (the pop frees the slot).
  - pop is legal only when valid=1. Pop with valid=0 is illegal even if push=1 in the same cycle; there is no fall-through.
- Illegal push: no write, pointer and count unchanged, overflow_err set next cycle.
- Illegal pop: ignored, underflow_err set next cycle. A legal push in the same cycle still proceeds.
- Count update on legal operations: +1 for push only, -1 for pop only, unchanged for simultaneous push and pop (both pointers advance).
- Flags are derived combinationally from the registered count: valid = count!=0; full and almost_full as defined in Ports.
- flush has priority over push and pop in the same cycle:
  - pointers and count return to 0 next cycle; nothing is written;
  - error flags are not affected by flush.
- clear_err: both error flags go to 0 next cycle. If a new error occurs in the same cycle as clear_err, setting wins.
- rst overrides flush, clear_err and all operations. Reset mid-operation discards all contents within one cycle.

Test Plan:
- FIFO_DEPTH=3, DATA_WIDTH=8: push 0x11, 0x22, 0x33 on consecutive cycles -> count 1,2,3; full=1 after the third push; pop three times -> data_out 0x11, 0x22, 0x33, then valid=0 and count=0.
- FIFO_DEPTH=3: perform 10 push/pop pairs in steady state with occupancy 1, data 0x00..0x09 -> data_out in order; verifies non-power-of-two pointer wrap with no lost or duplicated words.
- FIFO_DEPTH=3 with FIFO full: push 0x44 together with pop -> data_out 0x11 is consumed, count stays 3, overflow_err stays 0; then push alone while full -> overflow_err=1 next cycle, count=3, contents unchanged.
- Empty FIFO: pop=1 with push=1 and data_in 0x55 -> underflow_err=1 and count=1 next cycle, data_out=0x55; clear_err -> both error flags 0 next cycle.
- FIFO_DEPTH=4, AF_THRESHOLD=2: push two words -> almost_full=1 at count 2; flush in the same cycle as a push -> count=0, valid=0, almost_full=0 next cycle, and the pushed word is discarded.
- FIFO_DEPTH=1: alternate push/pop on values 0xA0..0xA3 -> full toggles 1/0 and data_out matches each word; assert rst while full -> count=0, valid=0, and both error flags 0 next cycle.
